// File: rtl/dmi_arbiter.sv
// Round-robin arbiter sharing one DMI slave between NUM_REQ DMI masters.
// One DM transaction in flight at a time; a timeout aborts a hung DM op.
module dmi_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
  input  logic [NUM_REQ*2-1:0]          req_op,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_W-1:0]             rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          dm_req_valid,
  input  logic                          dm_req_ready,
  output logic [ADDR_W-1:0]             dm_addr,
  output logic [DATA_W-1:0]             dm_wdata,
  output logic [1:0]                    dm_op,
  input  logic                          dm_rsp_valid,
  input  logic [DATA_W-1:0]             dm_rdata,
  input  logic [1:0]                    dm_resp,
  output logic                          dm_abort,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [1:0]          op_q, op_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;

  logic                grant_found;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    cand;
  logic [1:0]          sel_op;
  logic                timed_out;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_op    = req_op[int'(grant_idx)*2 +: 2];
  assign timed_out = (cnt_q == TO_VAL);

  // Handshakes: a requester transfers on the cycle req_valid & req_ready are
  // both high at the clock edge; the DM transfers when dm_req_valid & dm_req_ready.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    req_ready    = '0;
    rsp_valid    = '0;
    dm_req_valid = 1'b0;
    dm_abort     = 1'b0;

    if (state_q == S_ISSUE || state_q == S_WAIT_RSP) begin
      cnt_d = timed_out ? cnt_q : cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          last_grant_d = grant_idx;
          owner_d      = grant_idx;
          addr_d       = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
          wdata_d      = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
          op_d         = sel_op;
          unique case (sel_op)
            2'd1, 2'd2: begin
              state_d = S_ISSUE;
              cnt_d   = '0;
            end
            2'd0: begin
              state_d = S_RESP;
              resp_d  = 2'd0;
            end
            default: begin
              state_d = S_RESP;
              resp_d  = 2'd2;
            end
          endcase
        end
      end
      S_ISSUE: begin
        if (timed_out) begin
          dm_abort = 1'b1;
          rdata_d  = '0;
          resp_d   = 2'd3;
          state_d  = S_RESP;
        end else begin
          dm_req_valid = 1'b1;
          if (dm_req_ready) begin
            if (dm_rsp_valid) begin
              rdata_d = dm_rdata;
              resp_d  = dm_resp;
              state_d = S_RESP;
            end else begin
              state_d = S_WAIT_RSP;
            end
          end
        end
      end
      S_WAIT_RSP: begin
        if (timed_out) begin
          dm_abort = 1'b1;
          rdata_d  = '0;
          resp_d   = 2'd3;
          state_d  = S_RESP;
        end else if (dm_rsp_valid) begin
          rdata_d = dm_rdata;
          resp_d  = dm_resp;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        rsp_valid[owner_q] = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // last_grant resets to the top index so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      owner_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      op_q         <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      op_q         <= op_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
    end
  end

  assign dm_addr   = addr_q;
  assign dm_wdata  = wdata_q;
  assign dm_op     = op_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign owner     = owner_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dmi_arbiter.sv
// Randomized bench for dmi_arbiter: requester driver, reactive DM model,
// and a monitor popping expected grants/responses from scoreboard queues.
module tb_dmi_arbiter;
  localparam int NR    = 2;
  localparam int AW    = 7;
  localparam int DW    = 32;
  localparam int TO    = 15;
  localparam int IW    = $clog2(NR);
  localparam int EXP_W = 2 + DW + 2 + 16;

  logic              clk, rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_wdata;
  logic [NR*2-1:0]   req_op;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              dm_req_valid, dm_req_ready;
  logic [AW-1:0]     dm_addr;
  logic [DW-1:0]     dm_wdata;
  logic [1:0]        dm_op;
  logic              dm_rsp_valid;
  logic [DW-1:0]     dm_rdata;
  logic [1:0]        dm_resp;
  logic              dm_abort, busy;
  logic [IW-1:0]     owner;

  dmi_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_op(dm_op),
    .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata), .dm_resp(dm_resp),
    .dm_abort(dm_abort), .busy(busy), .owner(owner)
  );

  // DM behaviour per transaction: mode 0 normal, 1 never ready, 2 ready but no response
  typedef struct packed {
    logic [1:0]    mode;
    logic [7:0]    rdy;
    logic [7:0]    rsp;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [1:0]    op;
  } dm_cfg_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int n_abort_exp = 0;
  int n_abort_seen = 0;

  logic [EXP_W-1:0] exp_q[$];
  int               exp_grant_q[$];
  dm_cfg_t          cfg_q[$];

  bit            pending[NR];
  logic [1:0]    p_op[NR];
  logic [AW-1:0] p_addr[NR];
  logic [DW-1:0] p_wdata[NR];
  int            last_g;
  logic [DW-1:0] model_rdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Round-robin reference: first pending requester after the last grant.
  function automatic int pick();
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last_g + k) % NR;
      if (pending[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [1:0] op, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    pending[i] = 1'b1;
    p_op[i]    = op;
    p_addr[i]  = a;
    p_wdata[i] = d;
    req_valid[i] = 1'b1;
    req_op[i*2 +: 2]     = op;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic accept_one(input int mode, input int d, input int r, input logic [DW-1:0] data,
                            input logic [1:0] resp, input bit want_rsp);
    int g, lat;
    logic [DW-1:0] erd;
    logic [1:0] eresp;
    bit seen;
    dm_cfg_t c;
    logic [NR-1:0] oh;
    g = pick();
    if (g < 0) return;
    if (p_op[g] == 2'd1 || p_op[g] == 2'd2) begin
      c.mode = 2'(mode); c.rdy = 8'(d); c.rsp = 8'(r); c.data = data; c.resp = resp;
      c.addr = p_addr[g]; c.wdata = p_wdata[g]; c.op = p_op[g];
      cfg_q.push_back(c);
      if (mode == 0) begin
        erd = data; eresp = resp; lat = d + r + 2;
      end else begin
        erd = '0; eresp = 2'd3; lat = TO + 2;
        if (want_rsp) n_abort_exp++;
      end
    end else begin
      erd = model_rdata;
      eresp = (p_op[g] == 2'd0) ? 2'd0 : 2'd2;
      lat = 1;
    end
    model_rdata = erd;
    exp_grant_q.push_back(g);
    if (want_rsp) exp_q.push_back({2'(g), erd, eresp, 16'(lat)});
    seen = 1'b0;
    for (int n = 0; n < TO + 40; n++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = 1'b1;
        break;
      end
    end
    oh = '0;
    oh[g] = 1'b1;
    if (!seen) check("accept_wait", 64'(req_ready), 64'(oh));
    @(posedge clk);
    #1;
    req_valid[g] = 1'b0;
    pending[g] = 1'b0;
    last_g = g;
  endtask

  // Reactive DM model; also checks the fields the arbiter presents.
  initial begin
    dm_cfg_t c;
    dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rdata = '0; dm_resp = '0;
    forever begin
      @(negedge clk);
      if (!rst && dm_req_valid) begin
        if (cfg_q.size() == 0) begin
          check("dm_unexpected_req", 64'(dm_req_valid), 64'd0);
        end else begin
          c = cfg_q.pop_front();
          check("dm_addr", 64'(dm_addr), 64'(c.addr));
          check("dm_wdata", 64'(dm_wdata), 64'(c.wdata));
          check("dm_op", 64'(dm_op), 64'(c.op));
          repeat (c.rdy) @(negedge clk);
          if (c.mode != 2'd1) begin
            dm_req_ready = 1'b1;
            if (c.mode == 2'd0 && c.rsp == 8'd0) begin
              dm_rsp_valid = 1'b1; dm_rdata = c.data; dm_resp = c.resp;
            end
            @(negedge clk);
            dm_req_ready = 1'b0;
            dm_rsp_valid = 1'b0;
            if (!rst) check("dm_valid_drop", 64'(dm_req_valid), 64'd0);
            if (c.mode == 2'd0 && c.rsp > 8'd0) begin
              repeat (int'(c.rsp) - 1) @(negedge clk);
              dm_rsp_valid = 1'b1; dm_rdata = c.data; dm_resp = c.resp;
              @(negedge clk);
              dm_rsp_valid = 1'b0;
            end
          end
          if (c.mode != 2'd0) begin
            for (int n = 0; n < TO + 10; n++) begin
              if (dm_abort || rst) break;
              @(negedge clk);
            end
          end
        end
      end
    end
  end

  // Monitor: grants and responses are compared against the scoreboard queues.
  initial begin
    logic [EXP_W-1:0] e;
    logic [NR-1:0] oh;
    int g;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dm_abort) n_abort_seen++;
        if (rsp_valid != '0) begin
          if (exp_q.size() == 0) begin
            check("unexpected_rsp", 64'(rsp_valid), 64'd0);
          end else begin
            e = exp_q.pop_front();
            g = int'(e[EXP_W-1 -: 2]);
            oh = '0;
            oh[g] = 1'b1;
            check("rsp_valid", 64'(rsp_valid), 64'(oh));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e[DW+17:18]));
            check("rsp_resp", 64'(rsp_resp), 64'(e[17:16]));
            check("rsp_owner", 64'(owner), 64'(g));
            check("rsp_latency", 64'(cyc - accept_cyc), 64'(e[15:0]));
            check("rsp_busy", 64'(busy), 64'd1);
          end
        end
        if (req_ready != '0) begin
          if (exp_grant_q.size() == 0) begin
            check("unexpected_accept", 64'(req_ready), 64'd0);
          end else begin
            g = exp_grant_q.pop_front();
            oh = '0;
            oh[g] = 1'b1;
            check("grant", 64'(req_ready), 64'(oh));
            check("accept_busy", 64'(busy), 64'd0);
          end
          accept_cyc = cyc;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_dm_req_valid"}, 64'(dm_req_valid), 64'd0);
    check({tag, "_dm_abort"}, 64'(dm_abort), 64'd0);
    check({tag, "_owner"}, 64'(owner), 64'd0);
    check({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    check({tag, "_rsp_resp"}, 64'(rsp_resp), 64'd0);
    check({tag, "_dm_addr"}, 64'(dm_addr), 64'd0);
    check({tag, "_dm_wdata"}, 64'(dm_wdata), 64'd0);
    check({tag, "_dm_op"}, 64'(dm_op), 64'd0);
  endtask

  task automatic drain_pending();
    while (pick() >= 0) accept_one(0, 0, 0, $urandom, 2'd0, 1'b1);
  endtask

  task automatic wait_drain(input string tag);
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clk);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int mode, d, r, sel;
    logic [1:0] op;
    rst = 1'b1;
    req_valid = '0; req_addr = '0; req_wdata = '0; req_op = '0;
    for (int i = 0; i < NR; i++) pending[i] = 1'b0;
    last_g = NR - 1;
    model_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Minimum-latency WRITE from requester 0.
    set_req(0, 2'd2, 7'h10, 32'h8000_0001);
    accept_one(0, 0, 0, 32'h0, 2'd0, 1'b1);

    // Both requesters hold READs; grants must alternate.
    set_req(0, 2'd1, 7'h04, '0);
    set_req(1, 2'd1, 7'h05, '0);
    for (int k = 0; k < 4; k++) begin
      accept_one(0, 0, 0, (k % 2 == 0) ? 32'hDEAD_BEEF : 32'hCAFE_F00D, 2'd0, 1'b1);
      set_req(last_g, 2'd1, 7'(4 + last_g), '0);
    end
    drain_pending();

    // Slow DM: ready on the third ISSUE cycle, response five cycles later.
    set_req(0, 2'd1, 7'h11, '0);
    accept_one(0, 2, 5, 32'h1234_5678, 2'd0, 1'b1);

    // DM hangs: timeout, then the next request is served normally.
    set_req(1, 2'd2, 7'h3f, 32'h55);
    accept_one(1, 0, 0, '0, 2'd0, 1'b1);
    set_req(0, 2'd1, 7'h01, '0);
    accept_one(0, 1, 1, 32'hA5A5_A5A5, 2'd0, 1'b1);
    set_req(0, 2'd1, 7'h02, '0);
    accept_one(2, 3, 0, '0, 2'd0, 1'b1);

    // NOP and reserved op bypass the DM.
    set_req(1, 2'd0, 7'h20, 32'h1);
    accept_one(0, 0, 0, '0, 2'd0, 1'b1);
    set_req(1, 2'd3, 7'h21, 32'h2);
    accept_one(0, 0, 0, '0, 2'd0, 1'b1);

    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NR; i++) begin
        if (!pending[i] && $urandom_range(0, 1) == 1) begin
          sel = int'($urandom_range(0, 9));
          op = (sel == 0) ? 2'd0 : (sel == 1) ? 2'd3 : (sel < 6) ? 2'd1 : 2'd2;
          set_req(i, op, 7'($urandom), $urandom);
        end
      end
      if (pick() >= 0) begin
        sel = int'($urandom_range(0, 99));
        mode = (sel < 4) ? 1 : (sel < 8) ? 2 : 0;
        d = (mode == 1) ? 0 : int'($urandom_range(0, 5));
        r = int'($urandom_range(0, 6));
        accept_one(mode, d, r, $urandom, 2'($urandom_range(0, 3)), 1'b1);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    drain_pending();
    wait_drain("drain_random");
    check("abort_count", 64'(n_abort_seen), 64'(n_abort_exp));

    // Reset while waiting on the DM: no response, no abort, tie goes to 0.
    set_req(0, 2'd1, 7'h22, '0);
    accept_one(2, 0, 0, '0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_g = NR - 1;
    model_rdata = '0;
    @(posedge clk);
    #1;
    set_req(0, 2'd1, 7'h30, '0);
    set_req(1, 2'd1, 7'h31, '0);
    accept_one(0, 0, 0, 32'h0BAD_F00D, 2'd0, 1'b1);
    accept_one(0, 1, 0, 32'h600D_CAFE, 2'd0, 1'b1);
    wait_drain("drain_final");
    check("abort_count_final", 64'(n_abort_seen), 64'(n_abort_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
